gelato_pctable: RTL and testbench

- Per-warp program-counter table and warp scheduler. Feeds the instruction fetch unit with the selected pc, warp number and thread mask.
- Holds one PC, one thread mask and one state per warp. Warps are launched by the dispatcher and updated by the branch/writeback path.
- Round-robin picks a ready warp every cycle and drives it on a registered valid/ready issue port. That port drives the master side of the pctable-to-ifetch interface.

---
 rtl/gelato_pctable.sv | 141 ++++++++++++++
 tb/tb_gelato_pctable.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_pctable.sv
// gelato_pctable
//   Per-warp program-counter table and round-robin warp scheduler feeding
//   the instruction fetch unit. Each warp holds a PC, a thread mask and a
//   state (IDLE / READY / WAIT). The dispatcher launches IDLE warps.
//   The branch/writeback path updates WAIT warps back to READY, or retires
//   them to IDLE. Every cycle the issue register can load, it takes the
//   next READY warp in round-robin order.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   launch_*            dispatcher start request; launch_ready is
//                       combinational (the target warp is IDLE)
//   update_*            completion of a warp's in-flight instruction
//                       (next pc, new mask, exit flag)
//   issue_*             registered valid/ready master port toward ifetch
//   warp_active         per-warp "not IDLE" flags
//   all_idle            every warp IDLE and the issue slot empty
module gelato_pctable #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int WARP_W    = $clog2(WARP_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid,
  input  logic [WARP_W-1:0]     launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [THREAD_NUM-1:0] launch_mask,
  output logic                  launch_ready,
  input  logic                  update_valid,
  input  logic [WARP_W-1:0]     update_warp,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [THREAD_NUM-1:0] update_mask,
  input  logic                  update_exit,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [ADDR_WIDTH-1:0] issue_pc,
  output logic [WARP_W-1:0]     issue_warp_num,
  output logic [THREAD_NUM-1:0] issue_thread_mask,
  output logic [WARP_NUM-1:0]   warp_active,
  output logic                  all_idle
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2
  } warp_state_e;

  warp_state_e           state_q [WARP_NUM];
  logic [ADDR_WIDTH-1:0] pc_q    [WARP_NUM];
  logic [THREAD_NUM-1:0] mask_q  [WARP_NUM];
  logic [WARP_W-1:0]     rr_ptr_q;

  logic              launch_fire;
  logic              update_fire;
  logic              load;
  logic              sel_found;
  logic [WARP_W-1:0] sel_warp;

  // WARP_NUM is a power of two, so modulo wrap is plain truncation.
  function automatic logic [WARP_W-1:0] rr_idx(input logic [WARP_W-1:0] base,
                                               input int               off);
    logic [WARP_W-1:0] off_w;
    off_w = off[WARP_W-1:0];
    return base + off_w;
  endfunction

  // Launch and update legality are both judged on the registered state,
  // so at most one of launch/update/issue can touch a given warp per cycle.
  assign launch_ready = (state_q[launch_warp] == ST_IDLE);
  assign launch_fire  = launch_valid && launch_ready;
  assign update_fire  = update_valid && (state_q[update_warp] == ST_WAIT);
  assign load         = !issue_valid || issue_ready;

  // Round-robin search over registered state; a warp made READY this cycle
  // is therefore only visible next cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_warp  = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      if (!sel_found && state_q[rr_idx(rr_ptr_q, i)] == ST_READY) begin
        sel_found = 1'b1;
        sel_warp  = rr_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    warp_active = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      warp_active[w] = (state_q[w] != ST_IDLE);
    end
  end

  assign all_idle = (warp_active == '0) && !issue_valid;

  // ---- warp table and issue register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        state_q[w] <= ST_IDLE;
        pc_q[w]    <= '0;
        mask_q[w]  <= '0;
      end
      rr_ptr_q          <= '0;
      issue_valid       <= 1'b0;
      issue_pc          <= '0;
      issue_warp_num    <= '0;
      issue_thread_mask <= '0;
    end else begin
      for (int w = 0; w < WARP_NUM; w++) begin
        if (launch_fire && launch_warp == WARP_W'(w)) begin
          state_q[w] <= ST_READY;
          pc_q[w]    <= launch_pc;
          mask_q[w]  <= launch_mask;
        end else if (update_fire && update_warp == WARP_W'(w)) begin
          pc_q[w]    <= update_pc;
          mask_q[w]  <= update_mask;
          // An empty mask has no live threads left, so it retires the warp.
          state_q[w] <= (update_exit || update_mask == '0) ? ST_IDLE : ST_READY;
        end else if (load && sel_found && sel_warp == WARP_W'(w)) begin
          state_q[w] <= ST_WAIT;
        end
      end

      // Payload and rr_ptr only move on a hit; an empty search just drops valid.
      if (load) begin
        issue_valid <= sel_found;
        if (sel_found) begin
          issue_pc          <= pc_q[sel_warp];
          issue_warp_num    <= sel_warp;
          issue_thread_mask <= mask_q[sel_warp];
          rr_ptr_q          <= sel_warp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gelato_pctable.sv
module tb_gelato_pctable;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_valid;
  logic [1:0]  launch_warp;
  logic [31:0] launch_pc;
  logic [31:0] launch_mask;
  logic        launch_ready;
  logic        update_valid;
  logic [1:0]  update_warp;
  logic [31:0] update_pc;
  logic [31:0] update_mask;
  logic        update_exit;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_pc;
  logic [1:0]  issue_warp_num;
  logic [31:0] issue_thread_mask;
  logic [3:0]  warp_active;
  logic        all_idle;

  gelato_pctable #(.WARP_NUM(4), .THREAD_NUM(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_warp(launch_warp),
    .launch_pc(launch_pc), .launch_mask(launch_mask), .launch_ready(launch_ready),
    .update_valid(update_valid), .update_warp(update_warp), .update_pc(update_pc),
    .update_mask(update_mask), .update_exit(update_exit),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
    .issue_warp_num(issue_warp_num), .issue_thread_mask(issue_thread_mask),
    .warp_active(warp_active), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  warp;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] w, input logic [31:0] m);
    exp_t e;
    e.pc = pc; e.warp = w; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic do_launch(input logic [1:0] w, input logic [31:0] pc, input logic [31:0] m);
    launch_valid = 1'b1; launch_warp = w; launch_pc = pc; launch_mask = m;
  endtask

  task automatic do_update(input logic [1:0] w, input logic [31:0] pc,
                           input logic [31:0] m, input logic ex);
    update_valid = 1'b1; update_warp = w; update_pc = pc; update_mask = m; update_exit = ex;
  endtask

  task automatic idle_inputs();
    launch_valid = 1'b0;
    update_valid = 1'b0;
    update_exit  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted transfer must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue_warp", 64'(issue_warp_num), 64'hFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc",   64'(issue_pc), 64'(e.pc));
          chk("issue_warp", 64'(issue_warp_num), 64'(e.warp));
          chk("issue_mask", 64'(issue_thread_mask), 64'(e.mask));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; issue_ready = 1'b0;
    launch_warp = '0; launch_pc = '0; launch_mask = '0;
    update_warp = '0; update_pc = '0; update_mask = '0;
    idle_inputs();

    // Reset state
    apply_reset();
    at_neg();
    chk("rst_issue_valid", 64'(issue_valid), 64'h0);
    chk("rst_warp_active", 64'(warp_active), 64'h0);
    chk("rst_all_idle",    64'(all_idle), 64'h1);
    chk("rst_issue_pc",    64'(issue_pc), 64'h0);
    chk("rst_launch_ready", 64'(launch_ready), 64'h1);

    // Single launch, 2-cycle latency, no reissue while WAIT
    tick();
    issue_ready = 1'b1;
    do_launch(2'd2, 32'h1000, 32'hFFFF_FFFF);
    push(32'h1000, 2'd2, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    at_neg();
    chk("lat_cycle1_valid", 64'(issue_valid), 64'h0);
    tick();
    at_neg();
    chk("lat_cycle2_valid", 64'(issue_valid), 64'h1);
    repeat (4) tick();
    at_neg();
    chk("wait_no_reissue", 64'(issue_valid), 64'h0);
    chk("w2_active",       64'(warp_active), 64'h4);
    chk("not_all_idle",    64'(all_idle), 64'h0);

    // Four warps in order, then a pc+4 round
    apply_reset();
    for (int w = 0; w < 4; w++) begin
      do_launch(2'(w), 32'h100 * w, 32'h1111_1111 * (w + 1));
      push(32'h100 * w, 2'(w), 32'h1111_1111 * (w + 1));
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    at_neg();
    chk("round1_all_wait", 64'(warp_active), 64'hF);
    tick();
    for (int w = 0; w < 4; w++) begin
      do_update(2'(w), 32'h100 * w + 4, 32'h1111_1111 * (w + 1), 1'b0);
      push(32'h100 * w + 4, 2'(w), 32'h1111_1111 * (w + 1));
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Backpressure: warps 1 and 3 READY, slot held on warp 1
    issue_ready = 1'b0;
    do_update(2'd1, 32'h108, 32'h0000_FFFF, 1'b0);
    push(32'h108, 2'd1, 32'h0000_FFFF);
    tick();
    do_update(2'd3, 32'h308, 32'hFFFF_0000, 1'b0);
    push(32'h308, 2'd3, 32'hFFFF_0000);
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_valid", 64'(issue_valid), 64'h1);
      chk("bp_warp",  64'(issue_warp_num), 64'h1);
      chk("bp_pc",    64'(issue_pc), 64'h108);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    at_neg();
    chk("bp_release_warp3", 64'(issue_warp_num), 64'h3);
    chk("bp_release_valid", 64'(issue_valid), 64'h1);
    repeat (2) tick();

    // Retire warp 1 by empty mask, relaunch, retire by exit
    do_update(2'd1, 32'h10C, 32'h0, 1'b0);
    tick();
    idle_inputs();
    launch_warp = 2'd1;
    at_neg();
    chk("mask0_w1_idle",    64'(warp_active[1]), 64'h0);
    chk("mask0_w1_ready",   64'(launch_ready), 64'h1);
    tick();
    do_launch(2'd1, 32'h500, 32'hF);
    push(32'h500, 2'd1, 32'hF);
    tick();
    idle_inputs();
    repeat (3) tick();
    do_update(2'd1, 32'h504, 32'hF, 1'b1);
    tick();
    idle_inputs();
    at_neg();
    chk("exit_w1_idle", 64'(warp_active), 64'hD);

    // Illegal ops: launch on WAIT warp 0, update on IDLE warp 3
    launch_warp = 2'd0;
    at_neg();
    chk("wait_launch_ready", 64'(launch_ready), 64'h0);
    tick();
    do_launch(2'd0, 32'hDEAD, 32'hF);
    tick();
    idle_inputs();
    do_update(2'd3, 32'h30C, 32'h1, 1'b1);
    tick();
    do_update(2'd3, 32'hBEEF, 32'hF, 1'b0);
    tick();
    idle_inputs();
    repeat (3) tick();
    at_neg();
    chk("illegal_w3_idle",  64'(warp_active[3]), 64'h0);
    chk("illegal_active",   64'(warp_active), 64'h5);
    chk("illegal_no_issue", 64'(issue_valid), 64'h0);

    // Reset mid-operation with a held issue and 3 active warps
    issue_ready = 1'b0;
    do_update(2'd0, 32'h20, 32'hFF, 1'b0);
    do_launch(2'd1, 32'h600, 32'h3);
    tick();
    idle_inputs();
    tick();
    at_neg();
    chk("pre_rst_valid",  64'(issue_valid), 64'h1);
    chk("pre_rst_warp",   64'(issue_warp_num), 64'h0);
    chk("pre_rst_active", 64'(warp_active), 64'h7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    chk("mid_rst_valid",    64'(issue_valid), 64'h0);
    chk("mid_rst_active",   64'(warp_active), 64'h0);
    chk("mid_rst_all_idle", 64'(all_idle), 64'h1);
    tick();
    issue_ready = 1'b1;
    do_launch(2'd0, 32'h700, 32'h5);
    push(32'h700, 2'd0, 32'h5);
    tick();
    idle_inputs();
    repeat (4) tick();
    at_neg();
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
